// File: rtl/uart_tx_if.sv
// Byte handshake between the system-side synchronizer/FIFO (master) and uart_tx (slave).
interface uart_tx_if;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       busy;

  modport master (output P_DATA, output Data_Valid, output PAR_EN, output PAR_TYP, input busy);
  modport slave  (input P_DATA, input Data_Valid, input PAR_EN, input PAR_TYP, output busy);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB-first, optional parity, stop; one bit per CLK.
// Define UART_TX_HOLD_BUF_EN to add a one-entry holding register for gapless back-to-back frames.
module uart_tx (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  tx_if,
  output logic      TX_OUT
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state, state_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] data_q, data_nx;
  logic       par_en_q, par_en_nx;
  logic       par_typ_q, par_typ_nx;
  logic       tx_q, tx_nx;
  logic       busy_q, busy_nx;
  logic       accept;

`ifdef UART_TX_HOLD_BUF_EN
  logic [7:0] hold_data, hold_data_nx;
  logic       hold_par_en, hold_par_en_nx;
  logic       hold_par_typ, hold_par_typ_nx;
  logic       hold_full, hold_full_nx;
  logic       drain, direct;
`endif

  assign accept      = tx_if.Data_Valid && !busy_q;
  assign tx_if.busy  = busy_q;
  assign TX_OUT      = tx_q;

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    data_nx    = data_q;
    par_en_nx  = par_en_q;
    par_typ_nx = par_typ_q;
`ifdef UART_TX_HOLD_BUF_EN
    hold_data_nx    = hold_data;
    hold_par_en_nx  = hold_par_en;
    hold_par_typ_nx = hold_par_typ;
    hold_full_nx    = hold_full;
    drain           = 1'b0;
    direct          = 1'b0;
`endif

    case (state)
      IDLE, STOP: begin
        state_nx = IDLE;
`ifdef UART_TX_HOLD_BUF_EN
        // A pending hold entry wins; otherwise a fresh accept starts directly.
        if (hold_full) begin
          drain    = 1'b1;
          state_nx = START;
        end else if (accept) begin
          direct   = 1'b1;
          state_nx = START;
        end
`else
        if (state == IDLE && accept) begin
          state_nx   = START;
          data_nx    = tx_if.P_DATA;
          par_en_nx  = tx_if.PAR_EN;
          par_typ_nx = tx_if.PAR_TYP;
        end
`endif
      end
      START: begin
        state_nx   = DATA;
        bit_cnt_nx = '0;
      end
      DATA: begin
        if (bit_cnt == 3'd7) begin
          state_nx   = par_en_q ? PARITY : STOP;
          bit_cnt_nx = '0;
        end else begin
          bit_cnt_nx = bit_cnt + 3'd1;
        end
      end
      PARITY:  state_nx = STOP;
      default: state_nx = IDLE;
    endcase

`ifdef UART_TX_HOLD_BUF_EN
    if (drain) begin
      data_nx      = hold_data;
      par_en_nx    = hold_par_en;
      par_typ_nx   = hold_par_typ;
      hold_full_nx = 1'b0;
    end else if (direct) begin
      data_nx    = tx_if.P_DATA;
      par_en_nx  = tx_if.PAR_EN;
      par_typ_nx = tx_if.PAR_TYP;
    end
    // Refill after a drain is allowed, so this comes after the clear above.
    if (accept && !direct) begin
      hold_data_nx    = tx_if.P_DATA;
      hold_par_en_nx  = tx_if.PAR_EN;
      hold_par_typ_nx = tx_if.PAR_TYP;
      hold_full_nx    = 1'b1;
    end
    busy_nx = hold_full_nx;
`else
    busy_nx = (state_nx != IDLE);
`endif

    // Line level is registered from the next state so TX_OUT and busy switch together.
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = data_nx[bit_cnt_nx];
      PARITY:  tx_nx = par_typ_nx ? ~^data_nx : ^data_nx;
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      data_q    <= data_nx;
      par_en_q  <= par_en_nx;
      par_typ_q <= par_typ_nx;
      tx_q      <= tx_nx;
      busy_q    <= busy_nx;
    end
  end

`ifdef UART_TX_HOLD_BUF_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_data    <= '0;
      hold_par_en  <= 1'b0;
      hold_par_typ <= 1'b0;
      hold_full    <= 1'b0;
    end else begin
      hold_data    <= hold_data_nx;
      hold_par_en  <= hold_par_en_nx;
      hold_par_typ <= hold_par_typ_nx;
      hold_full    <= hold_full_nx;
    end
  end
`endif

endmodule
